sdram_traffic_checker: RTL

//  Synthesizable write-then-readback traffic generator and checker for the SDRAM controller user port.

---
 rtl/sdram_tc_pkg.sv | 33 +++
 rtl/sdram_pattern_gen.sv | 53 +++++
 rtl/sdram_traffic_checker.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_tc_pkg.sv
// Shared definitions for the SDRAM traffic checker: FSM encoding, pattern modes and
// per-width LFSR feedback taps.
package sdram_tc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitInit,
      StWrReq,
      StWrData,
      StRdReq,
      StRdData,
      StFin
   } tc_state_e;

   localparam logic ModeInc  = 1'b0;
   localparam logic ModeLfsr = 1'b1;

   // Feedback tap mask for a right-shifting LFSR: bit 0 plus bit (W-k) for every x^k term.
   // Width 16 is x^16+x^14+x^13+x^11+1, which steps 16'hACE1 to 16'h5670.
   function automatic logic [63:0] lfsr_taps(input int unsigned width);
      logic [63:0] taps;
      case (width)
         4:       taps = 64'h0000_0000_0000_0003;
         8:       taps = 64'h0000_0000_0000_001D;
         16:      taps = 64'h0000_0000_0000_002D;
         24:      taps = 64'h0000_0000_0000_0087;
         32:      taps = 64'h0000_0000_C000_0401;
         default: taps = 64'h0000_0000_0000_002D;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Data pattern generator: incrementing word or LFSR sequence, loaded at pass start and
// stepped once per beat.
module sdram_pattern_gen
   import sdram_tc_pkg::*;
#(
   parameter int unsigned DataW    = 16,
   parameter logic [63:0] BaseWord = 64'h0,
   parameter logic [63:0] Seed     = 64'hACE1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             mode_i,
   input  logic             advance_i,
   output logic [DataW-1:0] word_o
);

   localparam logic [63:0]      Taps64 = lfsr_taps(DataW);
   localparam logic [DataW-1:0] Taps   = Taps64[DataW-1:0];
   localparam logic [DataW-1:0] SeedW  = Seed[DataW-1:0];
   localparam logic [DataW-1:0] BaseW  = BaseWord[DataW-1:0];

   logic [DataW-1:0] word_q, word_d;
   logic             mode_q, mode_d;

   always_comb begin
      word_d = word_q;
      mode_d = mode_q;
      if (load_i) begin
         mode_d = mode_i;
         word_d = (mode_i == ModeLfsr) ? SeedW : BaseW;
      end else if (advance_i) begin
         if (mode_q == ModeLfsr) begin
            word_d = {^(word_q & Taps), word_q[DataW-1:1]};
         end else begin
            word_d = word_q + DataW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_q <= '0;
         mode_q <= ModeInc;
      end else begin
         word_q <= word_d;
         mode_q <= mode_d;
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/sdram_traffic_checker.sv
// Write-then-readback traffic generator and checker for the SDRAM controller user port.
// Writes NUM_BURSTS bursts, reads them back, counts mismatching beats and flags timeouts.
module sdram_traffic_checker
   import sdram_tc_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned NUM_BURSTS = 16,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned SEED       = 32'hACE1,
   parameter int unsigned TIMEOUT    = 4096,
   parameter int unsigned ERR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic              init_done,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_ack,
   input  logic              wr_data_req,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic              rd_data_vld,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam int unsigned BeatW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned BurstW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);

   localparam logic [BeatW-1:0]  BeatLast  = BeatW'(BURST_LEN - 1);
   localparam logic [BurstW-1:0] BurstLast = BurstW'(NUM_BURSTS - 1);
   // Abort one count early so done lands exactly TIMEOUT cycles after the wait begins.
   localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TIMEOUT - 2);
   localparam logic [ADDR_W-1:0] BaseAddr  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] BurstStep = ADDR_W'(BURST_LEN);

   tc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BeatW-1:0]  beat_q, beat_d;
   logic [BurstW-1:0] burst_q, burst_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              wr_req_q, wr_req_d;
   logic              rd_req_q, rd_req_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;

   logic              start_ok, wr_adv, rd_adv, mismatch, active, evt;
   logic [DATA_W-1:0] wr_word, chk_word;

   assign start_ok = (state_q == StIdle) && start && !done_q;
   assign wr_adv   = (state_q == StWrData) && wr_data_req;
   assign rd_adv   = (state_q == StRdData) && rd_data_vld;
   assign mismatch = rd_adv && (rd_data != chk_word);
   assign active   = (state_q == StWrReq) || (state_q == StWrData) ||
                     (state_q == StRdReq) || (state_q == StRdData);
   assign evt      = ((state_q == StWrReq) && wr_ack) || wr_adv ||
                     ((state_q == StRdReq) && rd_ack) || rd_adv;

   sdram_pattern_gen #(
      .DataW    (DATA_W),
      .BaseWord (64'(BASE_ADDR)),
      .Seed     (64'(SEED))
   ) u_wr_gen (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .load_i    (start_ok),
      .mode_i    (mode),
      .advance_i (wr_adv),
      .word_o    (wr_word)
   );

   sdram_pattern_gen #(
      .DataW    (DATA_W),
      .BaseWord (64'(BASE_ADDR)),
      .Seed     (64'(SEED))
   ) u_chk_gen (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .load_i    (start_ok),
      .mode_i    (mode),
      .advance_i (rd_adv),
      .word_o    (chk_word)
   );

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      beat_d           = beat_q;
      burst_d          = burst_q;
      tmo_d            = '0;
      wr_req_d         = wr_req_q;
      rd_req_d         = rd_req_q;
      busy_d           = busy_q;
      done_d           = 1'b0;
      pass_d           = pass_q;
      timeout_d        = timeout_q;
      err_cnt_d        = err_cnt_q;
      first_err_addr_d = first_err_addr_q;

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               err_cnt_d        = '0;
               pass_d           = 1'b0;
               timeout_d        = 1'b0;
               first_err_addr_d = '0;
               busy_d           = 1'b1;
               addr_d           = BaseAddr;
               beat_d           = '0;
               burst_d          = '0;
               state_d          = StWaitInit;
            end
         end
         StWaitInit: begin
            if (init_done) begin
               wr_req_d = 1'b1;
               state_d  = StWrReq;
            end
         end
         StWrReq: begin
            if (wr_ack) begin
               wr_req_d = 1'b0;
               beat_d   = '0;
               state_d  = StWrData;
            end
         end
         StWrData: begin
            if (wr_data_req) begin
               if (beat_q == BeatLast) begin
                  beat_d = '0;
                  if (burst_q == BurstLast) begin
                     burst_d  = '0;
                     addr_d   = BaseAddr;
                     rd_req_d = 1'b1;
                     state_d  = StRdReq;
                  end else begin
                     burst_d  = burst_q + BurstW'(1);
                     addr_d   = addr_q + BurstStep;
                     wr_req_d = 1'b1;
                     state_d  = StWrReq;
                  end
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         StRdReq: begin
            if (rd_ack) begin
               rd_req_d = 1'b0;
               beat_d   = '0;
               state_d  = StRdData;
            end
         end
         StRdData: begin
            if (rd_data_vld) begin
               if (mismatch) begin
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
                  if (err_cnt_q == '0) begin
                     first_err_addr_d = addr_q + ADDR_W'(beat_q);
                  end
               end
               if (beat_q == BeatLast) begin
                  beat_d = '0;
                  if (burst_q == BurstLast) begin
                     state_d = StFin;
                  end else begin
                     burst_d  = burst_q + BurstW'(1);
                     addr_d   = addr_q + BurstStep;
                     rd_req_d = 1'b1;
                     state_d  = StRdReq;
                  end
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         StFin: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_cnt_q == '0) && !timeout_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (active && !evt) begin
         if (tmo_q == TmoLast) begin
            wr_req_d  = 1'b0;
            rd_req_d  = 1'b0;
            timeout_d = 1'b1;
            state_d   = StFin;
         end else begin
            tmo_d = tmo_q + TmoW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= StIdle;
         addr_q           <= '0;
         beat_q           <= '0;
         burst_q          <= '0;
         tmo_q            <= '0;
         wr_req_q         <= 1'b0;
         rd_req_q         <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         timeout_q        <= 1'b0;
         err_cnt_q        <= '0;
         first_err_addr_q <= '0;
      end else begin
         state_q          <= state_d;
         addr_q           <= addr_d;
         beat_q           <= beat_d;
         burst_q          <= burst_d;
         tmo_q            <= tmo_d;
         wr_req_q         <= wr_req_d;
         rd_req_q         <= rd_req_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
         timeout_q        <= timeout_d;
         err_cnt_q        <= err_cnt_d;
         first_err_addr_q <= first_err_addr_d;
      end
   end

   assign wr_req         = wr_req_q;
   assign wr_addr        = addr_q;
   assign wr_data        = wr_word;
   assign rd_req         = rd_req_q;
   assign rd_addr        = addr_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign timeout        = timeout_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_addr_q;

endmodule
